fdd_drive: RTL and testbench
============================

FDD_DRIVE -- requirements
Module: fdd_drive

Interface
REQ-001 Parameter sysCLK, 21477270, system clock frequency in Hz.
REQ-002 Parameter ROT_TICKS, sysCLK/5, clk_sys cycles per revolution (300 rpm).
REQ-003 Parameter IDX_TICKS, sysCLK/250, index pulse width in cycles (4 ms).
REQ-004 Parameter MAX_TRACK, 79, highest head position.
REQ-005 clk_sys  in  1  system clock; the block's only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 img_mounted  in  1  image present (level); img_wp  in  1  image write-protected; img_spt  in  5  sectors per track (1..31).
REQ-008 motor_on  in  1  FDC motor enable; side  in  1  head select; step  in  1  step strobe, active on rising edge; dir  in  1  1=inward (track+1).
REQ-009 rd_req  in  1  one-cycle sector read request; rd_sector  in  5  sector number, 1-based.
REQ-010 index  out  1  index pulse; track0  out  1  head at track 0; ready  out  1  drive ready; wprot  out  1  write protect.
REQ-011 track  out  7  current head position.
REQ-012 rd_done  out  1  one-cycle completion strobe; rd_err  out  1  error flag, valid with rd_done.
REQ-013 sd_lba  out  32  image LBA; sd_rd  out  1  SD read request level; sd_ack  in  1  host acknowledge level.
REQ-014 sd_buff_addr  in  9, sd_buff_dout  in  8, sd_buff_wr  in  1  host byte write port.
REQ-015 buf_addr  in  9, buf_q  out  8  FDC-side sector buffer read, 1-cycle registered latency.

Function
REQ-016 Head: on each step rising edge, track increments if dir=1 and track<MAX_TRACK, decrements if dir=0 and track>0, else holds; track0 = (track==0).
REQ-017 Step edges are sampled regardless of motor_on, ready or read state.
REQ-018 Rotation: counter rot_cnt runs 0..ROT_TICKS-1, wraps to 0, and advances only while motor_on & img_mounted; otherwise it holds.
REQ-019 index = 1 when rot_cnt < IDX_TICKS and motor_on & img_mounted, else 0.
REQ-020 Spin-up: ready sets once two rot_cnt wraps have occurred since motor_on & img_mounted became true; it clears in the same cycle either input falls, and the wrap count restarts.
REQ-021 wprot = img_wp & img_mounted.
REQ-022 Read FSM states: IDLE, CHECK, SD_REQ, SD_XFER, DONE.
REQ-023 IDLE: rd_req=1 -> CHECK, latching rd_sector, track and side; rd_req is ignored in all other states.
REQ-024 CHECK, one cycle: the request is an error if ready=0, or the sector is 0, or the sector > img_spt. Error -> DONE with rd_err=1. Otherwise -> SD_REQ with sd_lba = (track*2+side)*img_spt + sector-1, computed zero-extended to 32 bits.
REQ-025 SD_REQ: hold sd_rd=1 until sd_ack=1, then go to SD_XFER and clear sd_rd in the same cycle.
REQ-026 SD_XFER: each sd_buff_wr writes sd_buff_dout at sd_buff_addr into a 512x8 buffer. Falling sd_ack -> DONE with rd_err=0.
REQ-027 DONE: pulse rd_done for exactly one cycle, then go to IDLE. rd_err holds its value until the next CHECK.
REQ-028 Latency: an error is reported with rd_done 2 cycles after rd_req. On success, rd_done occurs 1 cycle after sd_ack falls.
REQ-029 img_mounted falling in SD_REQ: drop sd_rd and go to DONE with rd_err=1. In SD_XFER, keep waiting for sd_ack to fall, then report rd_err=1.
REQ-030 Writes to the buffer while not in SD_XFER are ignored. buf_q reads are allowed at any time.

Reset
REQ-031 Reset values: track=0, rot_cnt=0, wrap count=0, FSM=IDLE, index=0, ready=0, rd_done=0, rd_err=0, sd_rd=0, sd_lba=0. track0=1. Buffer contents are undefined.
REQ-032 Reset mid-read: sd_rd drops in the next cycle and no rd_done is produced. The host is expected to release sd_ack on its own.

Verification (bench parameters: ROT_TICKS=100, IDX_TICKS=4)
REQ-033 Step boundaries: dir=0 with 3 step edges at track 0 -> track=0, track0=1. dir=1 with 85 edges -> track=79, track0=0.
REQ-034 Spin-up: img_mounted=1, motor_on=1 -> index high during cycles 0..3 of each 100-cycle period; ready rises on the 2nd wrap (cycle 200); motor_on=0 -> ready=0 on the next cycle.
REQ-035 Read success: ready=1, track=5, side=1, img_spt=9, rd_sector=3 -> sd_lba=101 and sd_rd=1. Host acks and writes 512 bytes with data=addr[7:0], then drops sd_ack -> rd_done=1 with rd_err=0; buf_q at buf_addr=0x1FF returns 0xFF.
REQ-036 Read errors: rd_sector=0, or rd_sector=10 with img_spt=9, or ready=0 -> rd_done 2 cycles after rd_req with rd_err=1 and sd_rd never asserted.
REQ-037 Unmount during SD_REQ -> sd_rd=0 and rd_done with rd_err=1. Reset asserted during SD_XFER -> FSM=IDLE, no rd_done, track=0.

Source files
------------

// File: rtl/fdd_drive.sv
// Floppy drive model: head stepping, spindle/index timing, spin-up ready,
// and a sector-read sequencer that fetches one sector from an SD image into a 512-byte buffer.
module fdd_drive #(
    parameter int sysCLK    = 21477270,
    parameter int ROT_TICKS = sysCLK / 5,
    parameter int IDX_TICKS = sysCLK / 250,
    parameter int MAX_TRACK = 79
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_img_mounted,
    input  logic        i_img_wp,
    input  logic [4:0]  i_img_spt,
    input  logic        i_motor_on,
    input  logic        i_side,
    input  logic        i_step,
    input  logic        i_dir,
    input  logic        i_rd_req,
    input  logic [4:0]  i_rd_sector,
    output logic        o_index,
    output logic        o_track0,
    output logic        o_ready,
    output logic        o_wprot,
    output logic [6:0]  o_track,
    output logic        o_rd_done,
    output logic        o_rd_err,
    output logic [31:0] o_sd_lba,
    output logic        o_sd_rd,
    input  logic        i_sd_ack,
    input  logic [8:0]  i_sd_buff_addr,
    input  logic [7:0]  i_sd_buff_dout,
    input  logic        i_sd_buff_wr,
    input  logic [8:0]  i_buf_addr,
    output logic [7:0]  o_buf_q
);
    // state      | meaning
    // S_IDLE     | waiting for rd_req
    // S_CHECK    | validate request, compute LBA
    // S_SD_REQ   | sd_rd held until host acks
    // S_SD_XFER  | host streams sector bytes into the buffer
    // S_DONE     | one-cycle rd_done strobe
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SD_REQ, S_SD_XFER, S_DONE} state_t;

    localparam int             RW       = $clog2(ROT_TICKS);
    localparam logic [RW-1:0]  ROT_LAST = RW'(ROT_TICKS - 1);
    localparam logic [RW-1:0]  IDX_LIM  = RW'(IDX_TICKS);
    localparam logic [6:0]     TRK_MAX  = 7'(MAX_TRACK);

    state_t         r_state;
    state_t         w_next;
    logic           r_step_d;
    logic [6:0]     r_track;
    logic [RW-1:0]  r_rot;
    logic [1:0]     r_wraps;
    logic [4:0]     r_sec;
    logic [6:0]     r_trk_l;
    logic           r_side_l;
    logic           r_err;
    logic [31:0]    r_lba;
    logic [7:0]     r_buf [512];
    logic [7:0]     r_buf_q;
    logic           w_spin;
    logic           w_wrap;
    logic           w_bad;
    logic [31:0]    w_lba;

    assign w_spin = i_motor_on & i_img_mounted;
    assign w_wrap = (r_rot == ROT_LAST);

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_step_d <= 1'b0;
            r_track  <= 7'd0;
        end else begin
            r_step_d <= i_step;
            if (i_step && !r_step_d) begin
                if (i_dir && r_track < TRK_MAX)
                    r_track <= r_track + 7'd1;
                else if (!i_dir && r_track != 7'd0)
                    r_track <= r_track - 7'd1;
            end
        end
    end

    // Wrap count saturates at 2, which is exactly the ready condition.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_rot   <= '0;
            r_wraps <= 2'd0;
        end else if (!w_spin) begin
            r_wraps <= 2'd0;
        end else if (w_wrap) begin
            r_rot <= '0;
            if (r_wraps != 2'd2)
                r_wraps <= r_wraps + 2'd1;
        end else begin
            r_rot <= r_rot + 1'b1;
        end
    end

    assign o_ready  = w_spin & (r_wraps == 2'd2);
    assign o_index  = w_spin & (r_rot < IDX_LIM);
    assign o_wprot  = i_img_wp & i_img_mounted;
    assign o_track  = r_track;
    assign o_track0 = (r_track == 7'd0);

    assign w_bad = !o_ready || (r_sec == 5'd0) || (r_sec > i_img_spt);
    assign w_lba = 32'({r_trk_l, r_side_l}) * 32'(i_img_spt) + 32'(r_sec) - 32'd1;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_rd_req) w_next = S_CHECK;
            S_CHECK:   w_next = w_bad ? S_DONE : S_SD_REQ;
            S_SD_REQ: begin
                if (!i_img_mounted)
                    w_next = S_DONE;
                else if (i_sd_ack)
                    w_next = S_SD_XFER;
            end
            S_SD_XFER: if (!i_sd_ack) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_sec    <= 5'd0;
            r_trk_l  <= 7'd0;
            r_side_l <= 1'b0;
            r_err    <= 1'b0;
            r_lba    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_rd_req) begin
                        r_sec    <= i_rd_sector;
                        r_trk_l  <= r_track;
                        r_side_l <= i_side;
                    end
                end
                S_CHECK: begin
                    r_err <= w_bad;
                    if (!w_bad)
                        r_lba <= w_lba;
                end
                S_SD_REQ, S_SD_XFER: begin
                    if (!i_img_mounted)
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_rd_done = (r_state == S_DONE);
    assign o_rd_err  = r_err;
    assign o_sd_rd   = (r_state == S_SD_REQ);
    assign o_sd_lba  = r_lba;

    // Buffer has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk_sys) begin
        if (r_state == S_SD_XFER && i_sd_buff_wr)
            r_buf[i_sd_buff_addr] <= i_sd_buff_dout;
        r_buf_q <= r_buf[i_buf_addr];
    end

    assign o_buf_q = r_buf_q;
endmodule

// File: tb/tb_fdd_drive.sv
// Bench for fdd_drive: stepping, spin-up/index timing, sector reads and error paths,
// with read results scored against a queue of expected outcomes.
module tb_fdd_drive;
    logic        clk = 1'b0;
    logic        reset, img_mounted, img_wp, motor_on, side, step, dir, rd_req;
    logic [4:0]  img_spt, rd_sector;
    logic        index, track0, ready, wprot, rd_done, rd_err, sd_rd, sd_ack, sd_buff_wr;
    logic [6:0]  track;
    logic [31:0] sd_lba;
    logic [8:0]  sd_buff_addr, buf_addr;
    logic [7:0]  sd_buff_dout, buf_q;

    typedef struct {
        logic [31:0] lba;
        logic        err;
    } exp_t;
    exp_t        sb_q[$];
    logic [8:0]  bq_addr[$];
    logic [7:0]  bq_data[$];

    int n_checks = 0;
    int n_errors = 0;

    fdd_drive #(.sysCLK(21477270), .ROT_TICKS(100), .IDX_TICKS(4), .MAX_TRACK(79)) dut (
        .i_clk_sys(clk), .i_reset(reset), .i_img_mounted(img_mounted), .i_img_wp(img_wp),
        .i_img_spt(img_spt), .i_motor_on(motor_on), .i_side(side), .i_step(step), .i_dir(dir),
        .i_rd_req(rd_req), .i_rd_sector(rd_sector), .o_index(index), .o_track0(track0),
        .o_ready(ready), .o_wprot(wprot), .o_track(track), .o_rd_done(rd_done), .o_rd_err(rd_err),
        .o_sd_lba(sd_lba), .o_sd_rd(sd_rd), .i_sd_ack(sd_ack), .i_sd_buff_addr(sd_buff_addr),
        .i_sd_buff_dout(sd_buff_dout), .i_sd_buff_wr(sd_buff_wr), .i_buf_addr(buf_addr), .o_buf_q(buf_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; img_mounted = 1'b0; img_wp = 1'b1; motor_on = 1'b0; side = 1'b0;
        step = 1'b0; dir = 1'b0; rd_req = 1'b0; img_spt = 5'd9; rd_sector = 5'd0;
        sd_ack = 1'b0; sd_buff_addr = 9'd0; sd_buff_dout = 8'd0; sd_buff_wr = 1'b0; buf_addr = 9'd0;
        repeat (3) tick();
        n_checks++; if (track !== 7'd0)   begin n_errors++; $display("FAIL reset_track: got %0d expected 0", track); end
        n_checks++; if (track0 !== 1'b1)  begin n_errors++; $display("FAIL reset_track0: got %b expected 1", track0); end
        n_checks++; if (ready !== 1'b0)   begin n_errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++; if (index !== 1'b0)   begin n_errors++; $display("FAIL reset_index: got %b expected 0", index); end
        n_checks++; if (rd_done !== 1'b0) begin n_errors++; $display("FAIL reset_rd_done: got %b expected 0", rd_done); end
        n_checks++; if (rd_err !== 1'b0)  begin n_errors++; $display("FAIL reset_rd_err: got %b expected 0", rd_err); end
        n_checks++; if (sd_rd !== 1'b0)   begin n_errors++; $display("FAIL reset_sd_rd: got %b expected 0", sd_rd); end
        n_checks++; if (sd_lba !== 32'd0) begin n_errors++; $display("FAIL reset_sd_lba: got %0d expected 0", sd_lba); end
        n_checks++; if (wprot !== 1'b0)   begin n_errors++; $display("FAIL wprot_unmounted: got %b expected 0", wprot); end
        reset = 1'b0;
        tick();
        img_mounted = 1'b1;
        #1;
        n_checks++; if (wprot !== 1'b1)   begin n_errors++; $display("FAIL wprot_mounted: got %b expected 1", wprot); end
        img_wp = 1'b0;
        #1;
        n_checks++; if (wprot !== 1'b0)   begin n_errors++; $display("FAIL wprot_clear: got %b expected 0", wprot); end
        img_mounted = 1'b0;
        tick();
    endtask

    task automatic test_step();
        dir = 1'b0;
        for (int i = 0; i < 3; i++) begin step = 1'b1; tick(); step = 1'b0; tick(); end
        n_checks++; if (track !== 7'd0)  begin n_errors++; $display("FAIL step_low_track: got %0d expected 0", track); end
        n_checks++; if (track0 !== 1'b1) begin n_errors++; $display("FAIL step_low_track0: got %b expected 1", track0); end
        dir = 1'b1;
        for (int i = 0; i < 85; i++) begin step = 1'b1; tick(); step = 1'b0; tick(); end
        n_checks++; if (track !== 7'd79) begin n_errors++; $display("FAIL step_high_track: got %0d expected 79", track); end
        n_checks++; if (track0 !== 1'b0) begin n_errors++; $display("FAIL step_high_track0: got %b expected 0", track0); end
        // held step level must not keep stepping
        dir = 1'b0; step = 1'b1;
        repeat (4) tick();
        step = 1'b0; tick();
        n_checks++; if (track !== 7'd78) begin n_errors++; $display("FAIL step_level: got %0d expected 78", track); end
        for (int i = 0; i < 73; i++) begin step = 1'b1; tick(); step = 1'b0; tick(); end
        n_checks++; if (track !== 7'd5)  begin n_errors++; $display("FAIL step_to_5: got %0d expected 5", track); end
    endtask

    task automatic test_spinup();
        logic exp_idx, exp_rdy;
        img_mounted = 1'b1; motor_on = 1'b1;
        #1;
        for (int k = 0; k < 250; k++) begin
            exp_idx = ((k % 100) < 4);
            exp_rdy = (k >= 200);
            n_checks++; if (index !== exp_idx) begin n_errors++; $display("FAIL spin_index cycle %0d: got %b expected %b", k, index, exp_idx); end
            n_checks++; if (ready !== exp_rdy) begin n_errors++; $display("FAIL spin_ready cycle %0d: got %b expected %b", k, ready, exp_rdy); end
            tick();
        end
        motor_on = 1'b0;
        tick();
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL motor_off_ready: got %b expected 0", ready); end
        n_checks++; if (index !== 1'b0) begin n_errors++; $display("FAIL motor_off_index: got %b expected 0", index); end
        motor_on = 1'b1;
        tick();
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL respin_restart: got %b expected 0", ready); end
        for (int k = 0; k < 300 && ready !== 1'b1; k++) tick();
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL respin_timeout: ready got %b expected 1", ready); end
    endtask

    task automatic test_read_ok();
        exp_t e;
        img_spt = 5'd9; side = 1'b1; rd_sector = 5'd3;
        rd_req = 1'b1;
        sb_q.push_back('{lba: 32'd101, err: 1'b0});
        tick();
        rd_req = 1'b0;
        for (int k = 0; k < 10 && sd_rd !== 1'b1; k++) tick();
        n_checks++; if (sd_rd !== 1'b1) begin n_errors++; $display("FAIL ok_sd_rd: got %b expected 1", sd_rd); end
        n_checks++; if (sd_lba !== sb_q[0].lba) begin n_errors++; $display("FAIL ok_sd_lba: got %0d expected %0d", sd_lba, sb_q[0].lba); end
        sd_ack = 1'b1;
        tick();
        n_checks++; if (sd_rd !== 1'b0) begin n_errors++; $display("FAIL ok_sd_rd_drop: got %b expected 0", sd_rd); end
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i); sd_buff_dout = 8'(i); sd_buff_wr = 1'b1;
            tick();
        end
        sd_buff_wr = 1'b0;
        bq_addr.push_back(9'h1FF); bq_data.push_back(8'hFF);
        bq_addr.push_back(9'h00A); bq_data.push_back(8'h0A);
        bq_addr.push_back(9'h100); bq_data.push_back(8'h00);
        sd_ack = 1'b0;
        tick();
        n_checks++; if (rd_done !== 1'b1) begin n_errors++; $display("FAIL ok_rd_done: got %b expected 1", rd_done); end
        if (rd_done === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++; if (rd_err !== e.err) begin n_errors++; $display("FAIL ok_rd_err: got %b expected %b", rd_err, e.err); end
        end
        tick();
        n_checks++; if (rd_done !== 1'b0) begin n_errors++; $display("FAIL ok_rd_done_pulse: got %b expected 0", rd_done); end
        // writes outside a transfer must be dropped
        sd_buff_addr = 9'h00A; sd_buff_dout = 8'h55; sd_buff_wr = 1'b1;
        tick();
        sd_buff_wr = 1'b0;
        while (bq_addr.size() > 0) begin
            logic [8:0] a;
            logic [7:0] d;
            a = bq_addr.pop_front();
            d = bq_data.pop_front();
            buf_addr = a;
            tick();
            n_checks++; if (buf_q !== d) begin n_errors++; $display("FAIL buf_read addr %h: got %h expected %h", a, buf_q, d); end
        end
    endtask

    task automatic test_read_errors();
        exp_t e;
        logic [4:0] secs [3];
        logic       saw_rd;
        secs[0] = 5'd0; secs[1] = 5'd10; secs[2] = 5'd3;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) motor_on = 1'b0;
            rd_sector = secs[c];
            rd_req = 1'b1;
            sb_q.push_back('{lba: 32'd0, err: 1'b1});
            tick();
            rd_req = 1'b0;
            saw_rd = sd_rd;
            n_checks++; if (rd_done !== 1'b0) begin n_errors++; $display("FAIL err%0d_early_done: got %b expected 0", c, rd_done); end
            tick();
            saw_rd |= sd_rd;
            n_checks++; if (rd_done !== 1'b1) begin n_errors++; $display("FAIL err%0d_rd_done: got %b expected 1", c, rd_done); end
            if (rd_done === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++; if (rd_err !== e.err) begin n_errors++; $display("FAIL err%0d_rd_err: got %b expected %b", c, rd_err, e.err); end
            end
            tick();
            saw_rd |= sd_rd;
            n_checks++; if (saw_rd !== 1'b0) begin n_errors++; $display("FAIL err%0d_sd_rd: got %b expected 0", c, saw_rd); end
            n_checks++; if (rd_err !== 1'b1) begin n_errors++; $display("FAIL err%0d_err_hold: got %b expected 1", c, rd_err); end
        end
        motor_on = 1'b1;
        for (int k = 0; k < 300 && ready !== 1'b1; k++) tick();
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL err_respin_timeout: ready got %b expected 1", ready); end
    endtask

    task automatic test_unmount();
        exp_t e;
        rd_sector = 5'd1;
        rd_req = 1'b1;
        sb_q.push_back('{lba: 32'd99, err: 1'b1});
        tick();
        rd_req = 1'b0;
        for (int k = 0; k < 10 && sd_rd !== 1'b1; k++) tick();
        n_checks++; if (sd_rd !== 1'b1) begin n_errors++; $display("FAIL um_sd_rd: got %b expected 1", sd_rd); end
        n_checks++; if (sd_lba !== sb_q[0].lba) begin n_errors++; $display("FAIL um_sd_lba: got %0d expected %0d", sd_lba, sb_q[0].lba); end
        img_mounted = 1'b0;
        tick();
        n_checks++; if (sd_rd !== 1'b0)   begin n_errors++; $display("FAIL um_sd_rd_drop: got %b expected 0", sd_rd); end
        n_checks++; if (rd_done !== 1'b1) begin n_errors++; $display("FAIL um_rd_done: got %b expected 1", rd_done); end
        if (rd_done === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++; if (rd_err !== e.err) begin n_errors++; $display("FAIL um_rd_err: got %b expected %b", rd_err, e.err); end
        end
        tick();
        img_mounted = 1'b1;
        for (int k = 0; k < 300 && ready !== 1'b1; k++) tick();
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL um_respin_timeout: ready got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid_read();
        logic saw_done;
        rd_sector = 5'd2;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int k = 0; k < 10 && sd_rd !== 1'b1; k++) tick();
        n_checks++; if (sd_lba !== 32'd100) begin n_errors++; $display("FAIL rst_sd_lba: got %0d expected 100", sd_lba); end
        sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            sd_buff_addr = 9'(i); sd_buff_dout = 8'hA0; sd_buff_wr = 1'b1;
            tick();
        end
        sd_buff_wr = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++; if (sd_rd !== 1'b0)   begin n_errors++; $display("FAIL rst_sd_rd: got %b expected 0", sd_rd); end
        n_checks++; if (track !== 7'd0)   begin n_errors++; $display("FAIL rst_track: got %0d expected 0", track); end
        saw_done = rd_done;
        sd_ack = 1'b0;
        tick();
        saw_done |= rd_done;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(); saw_done |= rd_done; end
        n_checks++; if (saw_done !== 1'b0) begin n_errors++; $display("FAIL rst_no_done: got %b expected 0", saw_done); end
        n_checks++; if (sb_q.size() != 0)  begin n_errors++; $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_spinup();
        test_read_ok();
        test_read_errors();
        test_unmount();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
